// File: rtl/pc_seq_ctrl.sv
// Fetch-stage program-counter sequencer: PC register, writable branch-target
// table, call/return stack and IDLE/RUN/HALT run control.
//
// Control inputs are qualified only by stall. Whenever stall is low at a
// rising edge, the decoder controls take effect at that edge. Whenever stall
// is high, the decoder must hold them, and they are ignored.
module pc_seq_ctrl #(
    parameter int D           = 12,
    parameter int STACK_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stall,
    input  logic         halt_in,
    input  logic         branch_en,
    input  logic         call_en,
    input  logic         ret_en,
    input  logic [3:0]   branch_addr,
    input  logic         cfg_we,
    input  logic [3:0]   cfg_addr,
    input  logic [D-1:0] cfg_data,
    output logic [D-1:0] pc,
    output logic         fetch_valid,
    output logic         flush,
    output logic         done,
    output logic         stack_err,
    output logic [1:0]   state_dbg
);

    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [D-1:0]   PC_ONE = 1;
    localparam logic [SPW-1:0] SP_ONE = 1;
    localparam logic [SPW-1:0] SP_FULL = STACK_DEPTH[SPW-1:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [D-1:0]   tbl   [16];
    logic [D-1:0]   stack [STACK_DEPTH];
    logic [SPW-1:0] sp;

    logic [D-1:0] pc_d, pc_inc, target, top;
    logic         flush_d, push, pop, err_set, clr_stack, full, empty;

    assign pc_inc    = pc + PC_ONE;
    assign target    = tbl[branch_addr];
    assign full      = (sp == SP_FULL);
    assign empty     = (sp == '0);
    assign top       = stack[IW'(sp - SP_ONE)];
    assign state_dbg = state_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc;
        flush_d   = flush;
        push      = 1'b0;
        pop       = 1'b0;
        err_set   = 1'b0;
        clr_stack = 1'b0;
        if (!stall) begin
            flush_d = 1'b0;
            case (state_q)
                IDLE: begin
                    pc_d = '0;
                    if (start) state_d = RUN;
                end
                RUN: begin
                    if (halt_in) begin
                        state_d = HALT;
                    end else if (ret_en) begin
                        // Underflow falls through to a plain increment.
                        if (empty) begin
                            err_set = 1'b1;
                            pc_d    = pc_inc;
                        end else begin
                            pop     = 1'b1;
                            pc_d    = top;
                            flush_d = 1'b1;
                        end
                    end else if (call_en) begin
                        if (full) begin
                            err_set = 1'b1;
                            pc_d    = pc_inc;
                        end else begin
                            push    = 1'b1;
                            pc_d    = target;
                            flush_d = 1'b1;
                        end
                    end else if (branch_en) begin
                        pc_d    = target;
                        flush_d = 1'b1;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
                HALT: begin
                    if (start) begin
                        state_d   = IDLE;
                        pc_d      = '0;
                        clr_stack = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            pc          <= '0;
            flush       <= 1'b0;
            done        <= 1'b0;
            stack_err   <= 1'b0;
            fetch_valid <= 1'b0;
            sp          <= '0;
        end else begin
            state_q     <= state_d;
            pc          <= pc_d;
            flush       <= flush_d;
            done        <= (state_d == HALT);
            // Registered from the stall seen at this edge: one bubble after release.
            fetch_valid <= (state_d == RUN) && !stall;
            if (err_set) stack_err <= 1'b1;
            if (clr_stack)  sp <= '0;
            else if (push)  sp <= sp + SP_ONE;
            else if (pop)   sp <= sp - SP_ONE;
        end
    end

    // Stack storage needs no reset: entries above sp are never read.
    always_ff @(posedge clk) begin
        if (reset && push) stack[IW'(sp)] <= pc_inc;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) tbl[i] <= (i < 4) ? D'(13 + 12 * i) : '0;
        end else if (cfg_we) begin
            tbl[cfg_addr] <= cfg_data;
        end
    end

endmodule
